// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile_pkg
// Shared sizing constants and helpers for the write-back register file.
// Rev    : 1.0  initial release
// ============================================================================
package wb_regfile_pkg;

   localparam int WB_DSIZE = 16;
   localparam int WB_ASIZE = 4;
   localparam int WB_NREG  = 1 << WB_ASIZE;
   localparam int WB_CNT_W = 16;

   function automatic logic [WB_CNT_W-1:0] sat_inc(input logic [WB_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module : regfile_rdport
// One combinational read port; optional write-to-read bypass under the macro
// WB_REGFILE_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_rdport
   import wb_regfile_pkg::*;
#(
   parameter int DSIZE = WB_DSIZE,
   parameter int ASIZE = WB_ASIZE
) (
   input  logic [ASIZE-1:0]                  raddr,
   input  logic [(2**ASIZE)-1:0][DSIZE-1:0]  regs,
   input  logic                              byp_en,
   input  logic [ASIZE-1:0]                  waddr,
   input  logic [DSIZE-1:0]                  wdata,
   output logic [DSIZE-1:0]                  rdata
);

`ifdef WB_REGFILE_BYPASS_EN
   // byp_en already excludes address 0 and reset
   always_comb begin
      rdata = regs[raddr];
      if (byp_en && (raddr == waddr)) begin
         rdata = wdata;
      end
   end
`else
   logic w_unused;
   assign w_unused = &{1'b0, byp_en, waddr, wdata};
   assign rdata    = regs[raddr];
`endif

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile
// Write-back stage register file with saturating commit counter; bypass
// selected by WB_REGFILE_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DSIZE = WB_DSIZE,
   parameter int ASIZE = WB_ASIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wen_in,
   input  logic                 MemtoReg_in,
   input  logic [DSIZE-1:0]     aluout_in,
   input  logic [DSIZE-1:0]     dm_in,
   input  logic [ASIZE-1:0]     waddr_in,
   input  logic [ASIZE-1:0]     raddr1,
   input  logic [ASIZE-1:0]     raddr2,
   output logic [DSIZE-1:0]     rdata1,
   output logic [DSIZE-1:0]     rdata2,
   output logic [DSIZE-1:0]     wb_data,
   output logic [WB_CNT_W-1:0]  wcount
);

   logic [(2**ASIZE)-1:0][DSIZE-1:0] r_regs;
   logic [WB_CNT_W-1:0]              r_wcount;
   logic                             w_commit;
   logic                             w_byp_en;

   assign wb_data  = MemtoReg_in ? dm_in : aluout_in;
   assign w_commit = wen_in && (waddr_in != '0);
   assign w_byp_en = w_commit && rst;

   // Entry 0 is only ever reset, so it reads as zero permanently
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_regs   <= '0;
         r_wcount <= '0;
      end else if (w_commit) begin
         r_regs[waddr_in] <= wb_data;
         r_wcount         <= sat_inc(r_wcount);
      end
   end

   assign wcount = r_wcount;

   regfile_rdport #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_rdport1 (
      .raddr  (raddr1),
      .regs   (r_regs),
      .byp_en (w_byp_en),
      .waddr  (waddr_in),
      .wdata  (wb_data),
      .rdata  (rdata1)
   );

   regfile_rdport #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_rdport2 (
      .raddr  (raddr2),
      .regs   (r_regs),
      .byp_en (w_byp_en),
      .waddr  (waddr_in),
      .wdata  (wb_data),
      .rdata  (rdata2)
   );

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_wb_regfile
// Self-checking bench for wb_regfile against an array/counter reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        wen_in;
   logic        MemtoReg_in;
   logic [15:0] aluout_in;
   logic [15:0] dm_in;
   logic [3:0]  waddr_in;
   logic [3:0]  raddr1;
   logic [3:0]  raddr2;
   logic [15:0] rdata1;
   logic [15:0] rdata2;
   logic [15:0] wb_data;
   logic [15:0] wcount;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] mem [16];
   logic [15:0] cnt;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk         (clk),
      .rst         (rst),
      .wen_in      (wen_in),
      .MemtoReg_in (MemtoReg_in),
      .aluout_in   (aluout_in),
      .dm_in       (dm_in),
      .waddr_in    (waddr_in),
      .raddr1      (raddr1),
      .raddr2      (raddr2),
      .rdata1      (rdata1),
      .rdata2      (rdata2),
      .wb_data     (wb_data),
      .wcount      (wcount)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read value for the inputs currently being driven
   function automatic logic [15:0] model_rd(input logic [3:0] a);
      if (BYP && rst && wen_in && (waddr_in != 4'd0) && (a == waddr_in))
         return MemtoReg_in ? dm_in : aluout_in;
      if (!rst || a == 4'd0)
         return 16'h0000;
      return mem[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      cnt = 16'h0000;
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 16; i++) begin
         raddr1 = 4'(i);
         raddr2 = 4'(15 - i);
         #0.25;
         check({tag, ":rd1"}, rdata1, model_rd(raddr1));
         check({tag, ":rd2"}, rdata2, model_rd(raddr2));
      end
   endtask

   task automatic wr(input bit wen, input bit mtr, input logic [15:0] alu,
                     input logic [15:0] dm, input logic [3:0] wa,
                     input logic [3:0] r1, input logic [3:0] r2, input string tag);
      @(negedge clk);
      rst = 1'b1;
      wen_in = wen; MemtoReg_in = mtr; aluout_in = alu; dm_in = dm;
      waddr_in = wa; raddr1 = r1; raddr2 = r2;
      #1;
      check({tag, ":wb"}, wb_data, mtr ? dm : alu);
      check({tag, ":pre1"}, rdata1, model_rd(r1));
      check({tag, ":pre2"}, rdata2, model_rd(r2));
      @(posedge clk);
      #1;
      if (wen && wa != 4'd0) begin
         mem[wa] = mtr ? dm : alu;
         if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
      end
      check({tag, ":post1"}, rdata1, model_rd(r1));
      check({tag, ":post2"}, rdata2, model_rd(r2));
      check({tag, ":wcount"}, wcount, cnt);
   endtask

   initial begin
      logic [3:0] ra;
      int         nfill;

      clear_model();
      rst = 1'b0; wen_in = 1'b1; MemtoReg_in = 1'b0; aluout_in = 16'hDEAD;
      dm_in = 16'hBEEF; waddr_in = 4'd2; raddr1 = 4'd0; raddr2 = 4'd0;

      // Held in reset with a write presented: nothing may commit
      repeat (3) @(posedge clk);
      #1;
      read_all("reset");
      check("reset:wcount", wcount, 16'h0000);

      // Reset release coincides with the first write
      wr(1, 0, 16'h1234, 16'h0000, 4'd5, 4'd5, 4'd5, "wr5");
      wr(1, 1, 16'h0000, 16'hBEEF, 4'd7, 4'd7, 4'd5, "load7");
      wr(1, 0, 16'hFFFF, 16'h0000, 4'd0, 4'd0, 4'd0, "r0");
      wr(1, 0, 16'h1111, 16'h0000, 4'd3, 4'd5, 4'd7, "pre3");
      wr(1, 0, 16'hA5A5, 16'h0000, 4'd3, 4'd7, 4'd3, "byp3");
      wr(0, 0, 16'h5555, 16'h0000, 4'd3, 4'd3, 4'd3, "idle");

      for (int n = 0; n < 40; n++) begin
         ra = 4'($urandom_range(0, 15));
         wr($urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), 16'($urandom),
            ra, ($urandom_range(0, 1) != 0) ? ra : 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), "rand");
      end

      // Asynchronous reset in the middle of a write cycle
      @(negedge clk);
      wen_in = 1'b1; MemtoReg_in = 1'b0; aluout_in = 16'h7777; waddr_in = 4'd9;
      #2;
      rst = 1'b0;
      #0.1;
      clear_model();
      check("arst:wcount", wcount, 16'h0000);
      read_all("arst");
      @(posedge clk);
      #1;
      raddr1 = 4'd9; raddr2 = 4'd9;
      #0.1;
      check("arst:lost9", rdata1, 16'h0000);
      check("arst:wcount2", wcount, 16'h0000);

      wr(1, 0, 16'h0F0F, 16'h0000, 4'd9, 4'd9, 4'd9, "rel9");

      // Drive the counter into saturation
      nfill = 65535 - int'(cnt);
      for (int n = 0; n < nfill + 3; n++) begin
         @(negedge clk);
         wen_in = 1'b1; MemtoReg_in = 1'b0; waddr_in = 4'd1; aluout_in = 16'(n);
      end
      @(posedge clk);
      #1;
      mem[1] = 16'(nfill + 2);
      cnt    = 16'hFFFF;
      check("sat:wcount", wcount, cnt);
      wr(1, 0, 16'hC0DE, 16'h0000, 4'd1, 4'd1, 4'd1, "sat");
      wr(0, 0, 16'h0000, 16'h0000, 4'd0, 4'd5, 4'd1, "final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter DSIZE, default 16, data and register width in bits.
REQ-002 The block SHALL have parameter ASIZE, default 4, register address width (2**ASIZE registers).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-low.
REQ-005 Port wen_in, input, 1, write-back enable from the DM/WB pipeline register.
REQ-006 Port MemtoReg_in, input, 1, write-back source select: 1 = dm_in, 0 = aluout_in.
REQ-007 Port aluout_in, input, DSIZE, ALU result being written back.
REQ-008 Port dm_in, input, DSIZE, data-memory load result being written back.
REQ-009 Port waddr_in, input, ASIZE, destination register address.
REQ-010 Ports raddr1 and raddr2, input, ASIZE each, decode-stage read addresses.
REQ-011 Ports rdata1 and rdata2, output, DSIZE each, decode-stage read data.
REQ-012 Port wb_data, output, DSIZE, selected write-back value, for forwarding to EX.
REQ-013 Port wcount, output, 16, count of committed register writes since reset.

Function
REQ-014 wb_data SHALL equal dm_in when MemtoReg_in=1, else aluout_in, combinationally.
REQ-015 On each rising clk with rst high, wen_in=1 and waddr_in!=0, register[waddr_in] SHALL load wb_data.
REQ-016 Register 0 SHALL never be written and SHALL always read as 0.
REQ-017 A write with wen_in=1 and waddr_in=0 SHALL be dropped and SHALL NOT increment wcount.
REQ-018 rdata1/rdata2 SHALL be combinational reads of register[raddr1]/register[raddr2]; read latency is zero cycles.
REQ-019 wcount SHALL increment by 1 on every committed write, as defined by REQ-015.
REQ-020 wcount SHALL saturate at 16'hFFFF; it SHALL NOT wrap to 0.
REQ-021 Both read ports SHALL be able to read the same address in the same cycle with identical results.

Reset
REQ-022 While rst=0, all registers, and therefore rdata1/rdata2 for every address, SHALL read 0 without waiting for a clock edge.
REQ-023 While rst=0, wcount SHALL be 0.
REQ-024 A write presented in the same cycle that rst deasserts SHALL be committed on the first rising edge at which rst=1.
REQ-025 A write in progress when rst asserts mid-operation SHALL be lost.

Configuration
REQ-026 Macro WB_REGFILE_BYPASS_EN SHALL select write-to-read bypass.
REQ-027 With WB_REGFILE_BYPASS_EN defined, if wen_in=1, waddr_in!=0 and raddrN==waddr_in, rdataN SHALL return wb_data in the same cycle.
REQ-028 Without WB_REGFILE_BYPASS_EN, rdataN SHALL return the old stored value, and the new value SHALL appear the cycle after the edge.
REQ-029 Under either setting, bypass SHALL never apply to address 0 and SHALL never apply while rst=0.

Structure
REQ-030 DSIZE, ASIZE and the register count SHALL come from the shared define.v header/package; the block SHALL define no local duplicates.
REQ-031 The read-port mux including bypass SHALL be a sub-module, regfile_rdport, instantiated twice.
REQ-032 The storage array and wcount logic SHALL reside in wb_regfile.

Verification
REQ-033 Reset test: hold rst=0 for 3 clocks, read all 16 addresses -> every read is 0 and wcount=0.
REQ-034 Write test: wen_in=1, MemtoReg_in=0, aluout_in=16'h1234, waddr_in=5, one edge -> rdata1 with raddr1=5 is 16'h1234 and wcount=1.
REQ-035 Load-source test: MemtoReg_in=1, dm_in=16'hBEEF, aluout_in=16'h0000, waddr_in=7 -> register 7 reads 16'hBEEF.
REQ-036 R0 test: wen_in=1, waddr_in=0, aluout_in=16'hFFFF -> reads of address 0 give 0 and wcount is unchanged.
REQ-037 Bypass test: raddr2=3 and a write of 16'hA5A5 to register 3 in the same cycle -> rdata2 is 16'hA5A5 before the edge with the macro defined, and the old value without it.
REQ-038 Async-reset test: assert rst mid-cycle after 10 writes -> all registers and wcount are 0 immediately, before the next clk edge.
